// File: rtl/scard_pkg.sv
// Shared types and ISO 7816-3 limits for the smartcard contact activation sequencer.
package scard_pkg;

  typedef enum logic [3:0] {
    StOff,
    StPwrUp,
    StClkOn,
    StWaitAtr,
    StActive,
    StDRst,
    StDClk,
    StDIo,
    StDPwr
  } state_e;

  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_ATR_TIMEOUT = 2'd1,
    ST_ATR_EARLY   = 2'd2,
    ST_REMOVED     = 2'd3
  } status_e;

  // Production parameter choices must respect these card-side limits.
  localparam int unsigned ISO_RST_LOW_MIN = 400;
  localparam int unsigned ISO_ATR_MIN     = 400;
  localparam int unsigned ISO_ATR_MAX     = 40000;

  typedef struct packed {
    logic power_en;
    logic oe;
    logic clk_en;
    logic rst;
    logic io_hold_low;
    logic ready;
    logic busy;
  } pins_t;

  // Pin levels owned by each state; the output register always holds pins_of(state_q).
  function automatic pins_t pins_of(state_e s);
    pins_t p;
    p = '0;
    case (s)
      StPwrUp: begin
        p.power_en = 1'b1;
        p.oe       = 1'b1;
        p.busy     = 1'b1;
      end
      StClkOn: begin
        p.power_en = 1'b1;
        p.oe       = 1'b1;
        p.clk_en   = 1'b1;
        p.busy     = 1'b1;
      end
      StWaitAtr: begin
        p.power_en = 1'b1;
        p.oe       = 1'b1;
        p.clk_en   = 1'b1;
        p.rst      = 1'b1;
        p.busy     = 1'b1;
      end
      StActive: begin
        p.power_en = 1'b1;
        p.oe       = 1'b1;
        p.clk_en   = 1'b1;
        p.rst      = 1'b1;
        p.ready    = 1'b1;
      end
      StDRst: begin
        p.power_en = 1'b1;
        p.oe       = 1'b1;
        p.clk_en   = 1'b1;
        p.busy     = 1'b1;
      end
      StDClk: begin
        p.power_en = 1'b1;
        p.oe       = 1'b1;
        p.busy     = 1'b1;
      end
      StDIo: begin
        p.power_en    = 1'b1;
        p.oe          = 1'b1;
        p.io_hold_low = 1'b1;
        p.busy        = 1'b1;
      end
      StDPwr: begin
        p.io_hold_low = 1'b1;
        p.busy        = 1'b1;
      end
      default: begin
        p.io_hold_low = 1'b1;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/scard_sync_edge.sv
// Two-flop synchroniser for an asynchronous card-side level, plus a falling-edge strobe.
module scard_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  // [0] and [1] form the synchroniser; [2] is the previous synchronised level.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= {3{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o    = sync_q[1];
  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/scard_activation_seq.sv
// Cold-reset activation / ordered deactivation sequencer for the smartcard contacts.
// One shared counter times Vcc settle, RST-low, the ATR window and each deactivation step.
module scard_activation_seq
  import scard_pkg::*;
#(
  parameter int unsigned PWR_SETTLE  = 2400,
  parameter int unsigned RST_LOW_CYC = 500,
  parameter int unsigned ATR_MIN     = 400,
  parameter int unsigned ATR_MAX     = 40000,
  parameter int unsigned STEP_CYC    = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       card_clk_tick_i,
  input  logic       card_present_i,
  input  logic       io_i,
  input  logic       activate_i,
  input  logic       deactivate_i,
  output logic       card_power_en_o,
  output logic       card_oe_o,
  output logic       card_clk_en_o,
  output logic       card_rst_o,
  output logic       io_hold_low_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic [1:0] status_o
);

  localparam logic [CNT_W-1:0] PwrLoad  = CNT_W'(PWR_SETTLE - 1);
  localparam logic [CNT_W-1:0] RstLoad  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] StepLoad = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] AtrMin   = CNT_W'(ATR_MIN);
  localparam logic [CNT_W-1:0] AtrMax   = CNT_W'(ATR_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  status_e          status_q, status_d;
  pins_t            pins_q, pins_d;

  logic io_s, io_fall;
  logic present_s, present_fall;
  logic live;
  logic unused_io_s;

  // IO idles high, so it resets high to avoid a false start bit after reset release.
  scard_sync_edge #(
    .ResetVal(1'b1)
  ) u_io_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (io_i),
    .q_o    (io_s),
    .fall_o (io_fall)
  );

  scard_sync_edge #(
    .ResetVal(1'b0)
  ) u_present_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (card_present_i),
    .q_o    (present_s),
    .fall_o (present_fall)
  );

  assign unused_io_s = io_s;

  always_comb begin
    live = (state_q == StPwrUp) || (state_q == StClkOn) ||
           (state_q == StWaitAtr) || (state_q == StActive);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;

    unique case (state_q)
      StOff: begin
        // A simultaneous deactivate request cancels the activation.
        if (activate_i && !deactivate_i) begin
          if (present_s) begin
            state_d  = StPwrUp;
            cnt_d    = PwrLoad;
            status_d = ST_OK;
          end else begin
            status_d = ST_REMOVED;
          end
        end
      end

      StPwrUp: begin
        if (cnt_q == '0) begin
          state_d = StClkOn;
          cnt_d   = RstLoad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      StClkOn: begin
        if (card_clk_tick_i) begin
          if (cnt_q == '0) begin
            state_d = StWaitAtr;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      StWaitAtr: begin
        // The start bit takes priority, so an edge on the last legal tick still counts.
        if (io_fall) begin
          if (cnt_q < AtrMin) begin
            state_d  = StDRst;
            cnt_d    = StepLoad;
            status_d = ST_ATR_EARLY;
          end else begin
            state_d = StActive;
          end
        end else if (cnt_q >= AtrMax) begin
          state_d  = StDRst;
          cnt_d    = StepLoad;
          status_d = ST_ATR_TIMEOUT;
        end else if (card_clk_tick_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StActive: begin
        // Deactivation from here is handled by the common override below.
      end

      StDRst, StDClk, StDIo, StDPwr: begin
        if (cnt_q == '0) begin
          cnt_d = StepLoad;
          case (state_q)
            StDRst:  state_d = StDClk;
            StDClk:  state_d = StDIo;
            StDIo:   state_d = StDPwr;
            default: begin
              state_d = StOff;
              cnt_d   = '0;
            end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase

    // Removal or a host request aborts any powered state into the ordered shutdown.
    if (live) begin
      if (present_fall) begin
        state_d  = StDRst;
        cnt_d    = StepLoad;
        status_d = ST_REMOVED;
      end else if (deactivate_i) begin
        state_d  = StDRst;
        cnt_d    = StepLoad;
        status_d = status_q;
      end
    end

    pins_d = pins_of(state_d);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StOff;
      cnt_q    <= '0;
      status_q <= ST_OK;
      pins_q   <= pins_of(StOff);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      pins_q   <= pins_d;
    end
  end

  assign card_power_en_o = pins_q.power_en;
  assign card_oe_o       = pins_q.oe;
  assign card_clk_en_o   = pins_q.clk_en;
  assign card_rst_o      = pins_q.rst;
  assign io_hold_low_o   = pins_q.io_hold_low;
  assign ready_o         = pins_q.ready;
  assign busy_o          = pins_q.busy;
  assign status_o        = status_q;

endmodule

// File: doc/scard_activation_seq.md
Name: scard_activation_seq

Overview:
- Sequences the ISO 7816-3 cold-reset activation and deactivation of the smartcard contact interface.
- Drives card power, level-shifter enable, card clock gating, RST and the IO hold-low, then watches IO for the ATR start bit inside the legal window.
- Sits between the smartcard register block (request/status) and the card pins. It sits in front of the serial smartcard engine, which may only use IO once this block reports ready.

Parameters:
- PWR_SETTLE, 2400: clk_i cycles from VCC on to clock start (Vcc settle time).
- RST_LOW_CYC, 500: card-clock ticks with RST held low after clock start; must be at least 400.
- ATR_MIN, 400: minimum card-clock ticks from RST rising to the ATR start bit.
- ATR_MAX, 40000: maximum card-clock ticks from RST rising to the ATR start bit.
- STEP_CYC, 64: clk_i cycles between successive deactivation steps.
- CNT_W, 16: width of the single shared down/up counter; must hold max(PWR_SETTLE, ATR_MAX).

Ports:
- clk_i  in  1  system clock (the USB interface clock).
- reset_i  in  1  asynchronous, active-high reset.
- card_clk_tick_i  in  1  one-cycle strobe per card clock period, synchronous to clk_i.
- card_present_i  in  1  raw card-inserted switch; 2-FF synchronised internally.
- io_i  in  1  card IO pin level; 2-FF synchronised internally.
- activate_i  in  1  one-cycle activation request.
- deactivate_i  in  1  one-cycle deactivation request.
- card_power_en_o  out  1  VCC enable.
- card_oe_o  out  1  level-shifter enable.
- card_clk_en_o  out  1  card clock gate.
- card_rst_o  out  1  card RST pin (active-low reset to the card).
- io_hold_low_o  out  1  when 1, forces the IO pin low.
- ready_o  out  1  ATR received in window; IO is owned by the serial engine.
- busy_o  out  1  in any transitional state.
- status_o  out  2  0 = ok, 1 = atr_timeout, 2 = atr_early, 3 = card_removed; sticky until the next activate_i.

Behaviour:
- Reset values: all outputs 0, except io_hold_low_o = 1. State is OFF, counter is 0.
- All outputs are registered and are a pure function of the state register, so each changes one cycle after the transition that sets it.
- OFF:
  - activate_i && present → PWR_UP; counter loads PWR_SETTLE-1; status clears to 0.
  - activate_i with no card present → stay in OFF, status = 3.
  - Outputs: all 0 except io_hold_low_o = 1.
- PWR_UP:
  - power_en = oe = 1; io_hold_low_o = 0 (IO in reception mode); rst = 0.
  - Counter decrements every clk_i cycle. At 0 → CLK_ON, counter loads RST_LOW_CYC-1.
- CLK_ON:
  - clk_en = 1; rst = 0.
  - Counter decrements on card_clk_tick_i only. Tick while counter is 0 → WAIT_ATR, counter clears to 0.
- WAIT_ATR:
  - rst = 1. Counter increments on each tick.
  - A falling edge on the synchronised IO with counter < ATR_MIN → status 2, go to DEACT.
  - A falling edge with counter ≥ ATR_MIN → ACTIVE.
  - Counter reaching ATR_MAX with no edge → status 1, go to DEACT.
  - A falling edge and counter reaching ATR_MAX in the same cycle count as a valid ATR.
- ACTIVE:
  - ready_o = 1; busy_o = 0.
  - deactivate_i → DEACT.
- DEACT: a four-step chain, each step held for STEP_CYC clk_i cycles.
  - D_RST: rst = 0.
  - D_CLK: clk_en = 0.
  - D_IO: io_hold_low_o = 1.
  - D_PWR: power_en = oe = 0.
  - After D_PWR → OFF.
- Card removal: the synchronised card_present_i going low in any state other than OFF or the DEACT chain sets status 3. The next cycle jumps to D_RST. Removal during DEACT does not restart the chain.
- Ignored requests:
  - activate_i outside OFF is ignored.
  - deactivate_i in OFF or during DEACT is ignored.
  - deactivate_i in PWR_UP, CLK_ON or WAIT_ATR → D_RST with status unchanged.
- Simultaneous activate_i and deactivate_i: deactivate wins.
- busy_o = 1 in PWR_UP, CLK_ON, WAIT_ATR and every DEACT step.
- reset_i asserted mid-operation: outputs drop to their reset values immediately (asynchronously). The ordered DEACT chain is not performed.

Decomposition:
- Shared package scard_pkg:
  - state enum (OFF, PWR_UP, CLK_ON, WAIT_ATR, ACTIVE, D_RST, D_CLK, D_IO, D_PWR);
  - status codes ST_OK, ST_ATR_TIMEOUT, ST_ATR_EARLY, ST_REMOVED;
  - ISO minimums ISO_RST_LOW_MIN = 400, ISO_ATR_MIN = 400, ISO_ATR_MAX = 40000.
- One sub-module, scard_sync_edge: 2-FF synchroniser plus falling-edge detector, instantiated for io_i and card_present_i.
- The FSM and the shared counter stay in the top module.

Test Plan:
- Sim parameters PWR_SETTLE = 10, RST_LOW_CYC = 8, ATR_MIN = 4, ATR_MAX = 20, STEP_CYC = 3; tick every 4th clk_i; card present. Pulse activate_i, then drop IO on the 6th tick after RST rises → power_en at +1 clk_i, clk_en 10 clk_i later, rst high after 8 ticks, ready_o = 1, status 0.
- Same setup, IO held high → ready_o stays 0, status = 1 after tick 20. Then rst=0, clk_en=0, io_hold_low=1, power_en=0 at 3-cycle spacing; busy_o falls on entry to OFF.
- IO falls on tick 2 after RST rises → status = 2 and the DEACT chain runs.
- In ACTIVE, card_present_i drops → status = 3 and rst falls 3 clk_i cycles after the raw change (2 sync + 1). A following activate_i with no card present → stays in OFF, status 3.
- activate_i and deactivate_i pulsed together in OFF → stays in OFF. deactivate_i during CLK_ON → D_RST, status stays 0.
- reset_i asserted in WAIT_ATR → all outputs take their reset values at once, io_hold_low_o = 1. After release, a new activate_i restarts from PWR_UP.
